// File: rtl/profiler_axil_regs.sv
// ---------------------------------------------------------------------------
// profiler_axil_regs
//   AXI4-Lite slave with four read/write registers and two read-only
//   profiling counters.
//     0x00-0x0C : reg0..reg3 (RW, byte strobes honoured)
//     0x10      : CYCLE_CNT  (RO, +1 every clock out of reset)
//     0x14      : TXN_CNT    (RO, +1 per B or R handshake, errors included)
//     0x18-0x1C : unmapped (SLVERR, reads return 0)
//
// Ports
//   ACLK, ARESET        : clock, asynchronous active-high reset
//   S_AXI_AW*/W*/B*     : write address, write data, write response channels
//   S_AXI_AR*/R*        : read address, read data channels
//   slv_regs_o          : {reg3, reg2, reg1, reg0} to user logic
// ---------------------------------------------------------------------------
module profiler_axil_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [4*C_S_AXI_DATA_WIDTH-1:0] slv_regs_o
);

    localparam int unsigned DW   = C_S_AXI_DATA_WIDTH;
    localparam int unsigned AW   = C_S_AXI_ADDR_WIDTH;
    localparam int unsigned NB   = C_S_AXI_DATA_WIDTH / 8;
    localparam int unsigned IDXW = C_S_AXI_ADDR_WIDTH - 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wstate_e;
    typedef enum logic       {R_IDLE, R_DATA} rstate_e;

    // write channel state
    wstate_e            w_state_q, w_state_d;
    logic               awready_q, awready_d;
    logic               wready_q, wready_d;
    logic               bvalid_q, bvalid_d;
    logic [1:0]         bresp_q, bresp_d;
    logic [AW-1:0]      aw_addr_q, aw_addr_d;
    logic [DW-1:0]      w_data_q, w_data_d;
    logic [NB-1:0]      w_strb_q, w_strb_d;

    // read channel state
    rstate_e            r_state_q, r_state_d;
    logic               arready_q, arready_d;
    logic               rvalid_q, rvalid_d;
    logic [1:0]         rresp_q, rresp_d;
    logic [DW-1:0]      rdata_q, rdata_d;

    // register file and counters
    logic [DW-1:0]      regs_q [4];
    logic [DW-1:0]      regs_d [4];
    logic [DW-1:0]      cycle_cnt_q, cycle_cnt_d;
    logic [DW-1:0]      txn_cnt_q, txn_cnt_d;

    // commit path
    logic               do_commit;
    logic [AW-1:0]      c_addr;
    logic [DW-1:0]      c_data;
    logic [NB-1:0]      c_strb;
    logic [IDXW-1:0]    c_idx;

    // read mux
    logic [IDXW-1:0]    ar_idx;
    logic [DW-1:0]      rd_val;
    logic [1:0]         rd_resp;

    logic aw_fire, w_fire, b_fire, ar_fire, r_fire;

    assign aw_fire = awready_q & S_AXI_AWVALID;
    assign w_fire  = wready_q  & S_AXI_WVALID;
    assign b_fire  = bvalid_q  & S_AXI_BREADY;
    assign ar_fire = arready_q & S_AXI_ARVALID;
    assign r_fire  = rvalid_q  & S_AXI_RREADY;

    // Protection bits and the byte-lane part of addresses carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR[1:0], c_addr[1:0]};

    // ------------------------------------------------------------------
    // Write FSM. The commit happens on the edge where the second of the
    // AW/W handshakes completes, taking whichever half arrives live from
    // the bus and the other half from its holding register.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d = w_state_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        aw_addr_d = aw_addr_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        regs_d    = regs_q;
        do_commit = 1'b0;
        c_addr    = aw_addr_q;
        c_data    = w_data_q;
        c_strb    = w_strb_q;

        unique case (w_state_q)
            W_IDLE: begin
                if (aw_fire && w_fire) begin
                    do_commit = 1'b1;
                    c_addr    = S_AXI_AWADDR;
                    c_data    = S_AXI_WDATA;
                    c_strb    = S_AXI_WSTRB;
                end else if (aw_fire) begin
                    aw_addr_d = S_AXI_AWADDR;
                    w_state_d = W_HAVE_AW;
                end else if (w_fire) begin
                    w_data_d  = S_AXI_WDATA;
                    w_strb_d  = S_AXI_WSTRB;
                    w_state_d = W_HAVE_W;
                end
            end
            W_HAVE_AW: begin
                if (w_fire) begin
                    do_commit = 1'b1;
                    c_data    = S_AXI_WDATA;
                    c_strb    = S_AXI_WSTRB;
                end
            end
            W_HAVE_W: begin
                if (aw_fire) begin
                    do_commit = 1'b1;
                    c_addr    = S_AXI_AWADDR;
                end
            end
            W_RESP: begin
                if (b_fire) begin
                    bvalid_d  = 1'b0;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase

        c_idx = c_addr[AW-1:2];
        if (do_commit) begin
            w_state_d = W_RESP;
            bvalid_d  = 1'b1;
            if (c_idx < IDXW'(4)) begin
                for (int unsigned b = 0; b < NB; b++) begin
                    if (c_strb[b]) begin
                        regs_d[c_idx[1:0]][8*b +: 8] = c_data[8*b +: 8];
                    end
                end
                bresp_d = RESP_OKAY;
            end else begin
                bresp_d = RESP_SLVERR;
            end
        end

        awready_d = (w_state_d == W_IDLE) || (w_state_d == W_HAVE_W);
        wready_d  = (w_state_d == W_IDLE) || (w_state_d == W_HAVE_AW);
    end

    // ------------------------------------------------------------------
    // Read FSM. Data is sampled from the current register contents, so a
    // write committing on the same edge is not yet visible.
    // ------------------------------------------------------------------
    always_comb begin
        ar_idx  = S_AXI_ARADDR[AW-1:2];
        rd_val  = '0;
        rd_resp = RESP_OKAY;
        if (ar_idx < IDXW'(4)) begin
            rd_val = regs_q[ar_idx[1:0]];
        end else if (ar_idx == IDXW'(4)) begin
            rd_val = cycle_cnt_q;
        end else if (ar_idx == IDXW'(5)) begin
            rd_val = txn_cnt_q;
        end else begin
            rd_resp = RESP_SLVERR;
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        unique case (r_state_q)
            R_IDLE: begin
                if (ar_fire) begin
                    rdata_d   = rd_val;
                    rresp_d   = rd_resp;
                    rvalid_d  = 1'b1;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (r_fire) begin
                    rvalid_d  = 1'b0;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        arready_d = (r_state_d == R_IDLE);
    end

    assign cycle_cnt_d = cycle_cnt_q + DW'(1);
    assign txn_cnt_d   = txn_cnt_q + DW'(b_fire) + DW'(r_fire);

    // Readies are registered so they stay low throughout reset and rise
    // on the first edge after it is released.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            w_state_q   <= W_IDLE;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            bresp_q     <= '0;
            aw_addr_q   <= '0;
            w_data_q    <= '0;
            w_strb_q    <= '0;
            r_state_q   <= R_IDLE;
            arready_q   <= 1'b0;
            rvalid_q    <= 1'b0;
            rresp_q     <= '0;
            rdata_q     <= '0;
            cycle_cnt_q <= '0;
            txn_cnt_q   <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            w_state_q   <= w_state_d;
            awready_q   <= awready_d;
            wready_q    <= wready_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            aw_addr_q   <= aw_addr_d;
            w_data_q    <= w_data_d;
            w_strb_q    <= w_strb_d;
            r_state_q   <= r_state_d;
            arready_q   <= arready_d;
            rvalid_q    <= rvalid_d;
            rresp_q     <= rresp_d;
            rdata_q     <= rdata_d;
            cycle_cnt_q <= cycle_cnt_d;
            txn_cnt_q   <= txn_cnt_d;
            regs_q      <= regs_d;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign slv_regs_o    = {regs_q[3], regs_q[2], regs_q[1], regs_q[0]};

endmodule

// File: tb/tb_profiler_axil_regs.sv
// ---------------------------------------------------------------------------
// tb_profiler_axil_regs
//   Scoreboard bench for profiler_axil_regs. Driver tasks push the expected
//   B / R responses into queues; a monitor pops and compares them at every
//   B and R handshake. Inputs change 1 time unit after the rising edge,
//   outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_profiler_axil_regs;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic         ACLK = 1'b0;
    logic         ARESET = 1'b1;
    logic [4:0]   S_AXI_AWADDR = '0;
    logic [2:0]   S_AXI_AWPROT = '0;
    logic         S_AXI_AWVALID = 1'b0;
    logic         S_AXI_AWREADY;
    logic [31:0]  S_AXI_WDATA = '0;
    logic [3:0]   S_AXI_WSTRB = '0;
    logic         S_AXI_WVALID = 1'b0;
    logic         S_AXI_WREADY;
    logic [1:0]   S_AXI_BRESP;
    logic         S_AXI_BVALID;
    logic         S_AXI_BREADY = 1'b0;
    logic [4:0]   S_AXI_ARADDR = '0;
    logic [2:0]   S_AXI_ARPROT = '0;
    logic         S_AXI_ARVALID = 1'b0;
    logic         S_AXI_ARREADY;
    logic [31:0]  S_AXI_RDATA;
    logic [1:0]   S_AXI_RRESP;
    logic         S_AXI_RVALID;
    logic         S_AXI_RREADY = 1'b0;
    logic [127:0] slv_regs_o;

    always #5 ACLK = ~ACLK;

    profiler_axil_regs #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (5)
    ) dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .slv_regs_o    (slv_regs_o)
    );

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  r;
    } rexp_t;

    logic [1:0] exp_b [$];
    rexp_t      exp_r [$];
    int         checks = 0;
    int         errors = 0;
    int         tb_txn = 0;
    logic [31:0] tb_cyc;
    logic [1:0] mon_b;
    rexp_t      mon_r;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timeout waiting for DUT", name);
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // Reference cycle counter: counts edges since reset release.
    always @(posedge ACLK or posedge ARESET) begin
        if (ARESET) tb_cyc <= '0;
        else        tb_cyc <= tb_cyc + 32'd1;
    end

    // Monitor: every handshake visible on a falling edge completes on the
    // following rising edge.
    always @(negedge ACLK) begin
        if (ARESET) begin
            tb_txn = 0;
        end else begin
            if (S_AXI_BVALID && S_AXI_BREADY) begin
                tb_txn++;
                if (exp_b.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_unexpected: got response %0h expected none", S_AXI_BRESP);
                end else begin
                    mon_b = exp_b.pop_front();
                    chk("bresp", 128'(S_AXI_BRESP), 128'(mon_b));
                end
            end
            if (S_AXI_RVALID && S_AXI_RREADY) begin
                tb_txn++;
                if (exp_r.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL r_unexpected: got data %0h expected none", S_AXI_RDATA);
                end else begin
                    mon_r = exp_r.pop_front();
                    chk("rdata", 128'(S_AXI_RDATA), 128'(mon_r.d));
                    chk("rresp", 128'(S_AXI_RRESP), 128'(mon_r.r));
                end
            end
        end
    end

    // w_lead: cycles W is presented before AW. b_hold: cycles BREADY stays
    // low once BVALID is up; meanwhile a stray AW is offered and must stall.
    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int w_lead, input int b_hold, input logic [1:0] resp);
        bit aw_done = 0;
        bit w_done  = 0;
        int n = 0;
        exp_b.push_back(resp);
        S_AXI_AWADDR  = a;
        S_AXI_WDATA   = d;
        S_AXI_WSTRB   = s;
        S_AXI_WVALID  = 1'b1;
        S_AXI_AWVALID = (w_lead == 0);
        while (!(aw_done && w_done) && n < 50) begin
            @(negedge ACLK);
            if (S_AXI_AWVALID && S_AXI_AWREADY) aw_done = 1;
            if (S_AXI_WVALID && S_AXI_WREADY)   w_done  = 1;
            tick();
            n++;
            if (aw_done) S_AXI_AWVALID = 1'b0;
            if (w_done)  S_AXI_WVALID  = 1'b0;
            if (!aw_done && n >= w_lead) S_AXI_AWVALID = 1'b1;
        end
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        if (!(aw_done && w_done)) begin
            timeout("write_addr_data");
            return;
        end
        n = 0;
        @(negedge ACLK);
        while (!S_AXI_BVALID && n < 20) begin
            @(negedge ACLK);
            n++;
        end
        if (!S_AXI_BVALID) begin
            timeout("write_bvalid");
            return;
        end
        if (b_hold > 0) begin
            S_AXI_AWADDR  = 5'h0C;
            S_AXI_AWVALID = 1'b1;
        end
        for (int i = 0; i < b_hold; i++) begin
            chk("bvalid_hold", 128'(S_AXI_BVALID), 128'(1));
            chk("bresp_hold", 128'(S_AXI_BRESP), 128'(resp));
            chk("awready_hold", 128'(S_AXI_AWREADY), 128'(0));
            @(negedge ACLK);
        end
        tick();
        S_AXI_AWVALID = 1'b0;
        S_AXI_BREADY  = 1'b1;
        @(negedge ACLK);
        tick();
        S_AXI_BREADY  = 1'b0;
    endtask

    // use_cyc: expected data comes from the reference cycle counter at the
    // AR handshake instead of the argument.
    task automatic axi_read(input logic [4:0] a, input logic [31:0] d, input logic [1:0] resp,
                            input bit use_cyc, input int r_hold);
        bit done = 0;
        int n = 0;
        rexp_t e;
        e.d = d;
        e.r = resp;
        S_AXI_ARADDR  = a;
        S_AXI_ARVALID = 1'b1;
        while (!done && n < 50) begin
            @(negedge ACLK);
            if (S_AXI_ARVALID && S_AXI_ARREADY) begin
                done = 1;
                if (use_cyc) e.d = tb_cyc;
                exp_r.push_back(e);
            end
            tick();
            n++;
        end
        S_AXI_ARVALID = 1'b0;
        if (!done) begin
            timeout("read_addr");
            return;
        end
        n = 0;
        @(negedge ACLK);
        while (!S_AXI_RVALID && n < 20) begin
            @(negedge ACLK);
            n++;
        end
        if (!S_AXI_RVALID) begin
            timeout("read_rvalid");
            return;
        end
        for (int i = 0; i < r_hold; i++) begin
            chk("rvalid_hold", 128'(S_AXI_RVALID), 128'(1));
            chk("rdata_hold", 128'(S_AXI_RDATA), 128'(e.d));
            @(negedge ACLK);
        end
        tick();
        S_AXI_RREADY = 1'b1;
        @(negedge ACLK);
        tick();
        S_AXI_RREADY = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        rexp_t e;
        int n;

        // Reset state
        repeat (3) @(negedge ACLK);
        chk("rst_ready", 128'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 128'(0));
        chk("rst_valid", 128'({S_AXI_BVALID, S_AXI_RVALID}), 128'(0));
        chk("rst_rdata", 128'(S_AXI_RDATA), 128'(0));
        chk("rst_resp", 128'({S_AXI_BRESP, S_AXI_RRESP}), 128'(0));
        chk("rst_regs", slv_regs_o, 128'(0));
        @(posedge ACLK);
        #1 ARESET = 1'b0;
        @(negedge ACLK);
        chk("ready_before_edge", 128'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 128'(0));
        @(negedge ACLK);
        chk("ready_after_rst", 128'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 128'(3'b111));
        tick();

        // Basic write/readback and transaction count
        for (int i = 0; i < 4; i++) axi_write(5'(i * 4), 32'(i + 1), 4'hF, 0, 0, OKAY);
        for (int i = 0; i < 4; i++) axi_read(5'(i * 4), 32'(i + 1), OKAY, 0, 0);
        chk("regs_basic", slv_regs_o, {32'd4, 32'd3, 32'd2, 32'd1});
        axi_read(5'h14, 32'd8, OKAY, 0, 0);
        axi_read(5'h10, 32'd0, OKAY, 1, 2);

        // Byte strobes
        axi_write(5'h00, 32'hAABBCCDD, 4'hF, 0, 0, OKAY);
        axi_write(5'h00, 32'h11223344, 4'b0101, 0, 0, OKAY);
        axi_read(5'h00, 32'hAA22CC44, OKAY, 0, 0);
        axi_write(5'h00, 32'hFFFFFFFF, 4'b0000, 0, 0, OKAY);
        axi_read(5'h00, 32'hAA22CC44, OKAY, 0, 0);

        // W ahead of AW, BREADY held off
        axi_write(5'h08, 32'hCAFEF00D, 4'hF, 3, 5, OKAY);
        axi_read(5'h08, 32'hCAFEF00D, OKAY, 0, 1);
        chk("regs_after_hold", slv_regs_o, {32'd4, 32'hCAFEF00D, 32'd2, 32'hAA22CC44});

        // Read-only and unmapped accesses
        axi_write(5'h10, 32'h12345678, 4'hF, 0, 0, SLVERR);
        axi_write(5'h14, 32'h12345678, 4'hF, 0, 0, SLVERR);
        axi_write(5'h18, 32'h12345678, 4'hF, 0, 0, SLVERR);
        axi_read(5'h1C, 32'd0, SLVERR, 0, 0);
        axi_read(5'h18, 32'd0, SLVERR, 0, 0);
        axi_read(5'h10, 32'd0, OKAY, 1, 0);
        chk("regs_after_err", slv_regs_o, {32'd4, 32'hCAFEF00D, 32'd2, 32'hAA22CC44});

        // Same-edge read and write commit to the same register
        axi_write(5'h04, 32'h5, 4'hF, 0, 0, OKAY);
        exp_b.push_back(OKAY);
        e.d = 32'h5;
        e.r = OKAY;
        exp_r.push_back(e);
        S_AXI_AWADDR  = 5'h04;
        S_AXI_WDATA   = 32'h9;
        S_AXI_WSTRB   = 4'hF;
        S_AXI_ARADDR  = 5'h04;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        S_AXI_ARVALID = 1'b1;
        S_AXI_BREADY  = 1'b1;
        S_AXI_RREADY  = 1'b1;
        @(negedge ACLK);
        chk("same_cycle_ready", 128'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 128'(3'b111));
        tick();
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_ARVALID = 1'b0;
        @(negedge ACLK);
        chk("same_cycle_valid", 128'({S_AXI_BVALID, S_AXI_RVALID}), 128'(2'b11));
        tick();
        S_AXI_BREADY  = 1'b0;
        S_AXI_RREADY  = 1'b0;
        tick();
        axi_read(5'h04, 32'h9, OKAY, 0, 0);
        axi_read(5'h14, 32'(tb_txn), OKAY, 0, 0);

        // Reset while BVALID is pending
        S_AXI_AWADDR  = 5'h00;
        S_AXI_WDATA   = 32'hDEADBEEF;
        S_AXI_WSTRB   = 4'hF;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        n = 0;
        @(negedge ACLK);
        while (!S_AXI_BVALID && n < 20) begin
            @(negedge ACLK);
            n++;
        end
        chk("bvalid_before_rst", 128'(S_AXI_BVALID), 128'(1));
        #2 ARESET = 1'b1;
        #1;
        chk("bvalid_async_rst", 128'(S_AXI_BVALID), 128'(0));
        chk("regs_async_rst", slv_regs_o, 128'(0));
        chk("ready_async_rst", 128'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 128'(0));
        repeat (2) @(posedge ACLK);
        #1 ARESET = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            chk("no_b_after_rst", 128'(S_AXI_BVALID), 128'(0));
        end
        tick();
        axi_read(5'h14, 32'd0, OKAY, 0, 0);
        axi_read(5'h00, 32'd0, OKAY, 0, 0);
        axi_read(5'h10, 32'd0, OKAY, 1, 0);

        repeat (3) tick();
        chk("b_queue_empty", 128'(exp_b.size()), 128'(0));
        chk("r_queue_empty", 128'(exp_r.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/profiler_axil_regs.md
PROFILER_AXIL_REGS -- requirements
Module: profiler_axil_regs

Interface
REQ-001 C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
REQ-002 C_S_AXI_ADDR_WIDTH, 5, byte address width; covers offsets 0x00-0x1C.
REQ-003 ACLK  in  1  single clock; all state changes on its rising edge.
REQ-004 ARESET  in  1  reset, asynchronous, active-high.
REQ-005 S_AXI_AWADDR  in  5  write address; bits [1:0] ignored.
REQ-006 S_AXI_AWPROT  in  3  accepted, ignored.
REQ-007 S_AXI_AWVALID/S_AXI_AWREADY  in/out  1/1  write-address handshake.
REQ-008 S_AXI_WDATA  in  32, S_AXI_WSTRB  in  4, S_AXI_WVALID/S_AXI_WREADY  in/out  1/1  write-data channel.
REQ-009 S_AXI_BRESP  out  2, S_AXI_BVALID/S_AXI_BREADY  out/in  1/1  write response.
REQ-010 S_AXI_ARADDR  in  5, S_AXI_ARPROT  in  3 (ignored), S_AXI_ARVALID/S_AXI_ARREADY  in/out  1/1  read address.
REQ-011 S_AXI_RDATA  out  32, S_AXI_RRESP  out  2, S_AXI_RVALID/S_AXI_RREADY  out/in  1/1  read data.
REQ-012 slv_regs_o  out  128  {reg3,reg2,reg1,reg0} RW register contents to user logic.

Function
REQ-013 Map: 0x00-0x0C RW reg0-reg3; 0x10 RO CYCLE_CNT; 0x14 RO TXN_CNT; 0x18, 0x1C unmapped.
REQ-014 Write FSM states W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP; AWREADY=1 only in W_IDLE/W_HAVE_W, WREADY=1 only in W_IDLE/W_HAVE_AW.
REQ-015 AW and W accepted in either order or same cycle; AWADDR/WDATA/WSTRB registered at their handshakes.
REQ-016 Commit in the cycle after both are held: BVALID=1 next edge, state W_RESP, AWREADY=WREADY=0.
REQ-017 Commit to RW reg applies WSTRB per byte; WSTRB=0 leaves reg unchanged, BRESP=OKAY (00).
REQ-018 Write to 0x10/0x14 or unmapped: no state change, BRESP=SLVERR (10).
REQ-019 BVALID/BRESP held stable until BREADY; on BVALID&BREADY return to W_IDLE, ready high next cycle.
REQ-020 Read FSM states R_IDLE, R_DATA; ARREADY=1 only in R_IDLE.
REQ-021 AR handshake: RDATA/RRESP registered from value at that edge (pre-commit of a same-cycle write), RVALID=1 next cycle.
REQ-022 Unmapped read: RDATA=0, RRESP=SLVERR; all mapped reads RRESP=OKAY.
REQ-023 RVALID/RDATA/RRESP held stable until RREADY; return to R_IDLE after RVALID&RREADY.
REQ-024 Read and write FSMs independent; simultaneous read/write of same address legal per REQ-021.
REQ-025 CYCLE_CNT: 32-bit, +1 every cycle out of reset, wraps 0xFFFFFFFF->0.
REQ-026 TXN_CNT: 32-bit, +1 per B handshake and +1 per R handshake, +2 if both same cycle, wraps; errors also counted.
REQ-027 Minimum per-transaction occupancy: write 3 cycles (handshake, BVALID, BREADY), read 2 cycles.

Reset
REQ-028 ARESET=1 forces immediately: reg0-3=0, counters=0, BVALID=RVALID=0, AWREADY=WREADY=ARREADY=0, RDATA=0, BRESP=RRESP=0, FSMs idle.
REQ-029 Readies rise first cycle after ARESET deasserts; reset mid-transaction discards it, no response issued.

Verification
REQ-030 Write 0x1,0x2,0x3,0x4 to 0x00,0x04,0x08,0x0C (WSTRB=F), read back -> 0x1..0x4, all OKAY, TXN_CNT=8.
REQ-031 reg0=0xAABBCCDD, write 0x11223344 WSTRB=0101 -> read 0xAA22CC44.
REQ-032 W presented 3 cycles before AW, BREADY held low 5 cycles -> BVALID stable 5 cycles, one commit, no second AW accepted meanwhile.
REQ-033 Write 0x10 and read 0x1C -> BRESP=SLVERR, RRESP=SLVERR, RDATA=0, CYCLE_CNT unaffected.
REQ-034 reg1=0x5; same-cycle AR 0x04 and write-commit 0x9 to 0x04 -> RDATA=0x5, later read 0x9.
REQ-035 ARESET pulsed while BVALID=1 -> BVALID=0 at once, regs=0, no B handshake, TXN_CNT=0.
